// File: rtl/inst_mem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The loader sits on the slave side; the stream source and memory sit on the master side.
interface inst_mem_loader_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int instWidth  = 32
);
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [instWidth-1:0]  mem_wdata;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );
endinterface

// File: rtl/inst_mem_loader.sv
// Boot loader: framed byte stream -> little-endian instruction words,
// holding the core in reset until the image checksum verifies.
module inst_mem_loader #(
    parameter int instWidth  = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    inst_mem_loader_if.slave bus,
    output logic             cpu_rst,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_e;

    localparam logic [16:0] MAX_N = 17'd1 << ADDR_WIDTH;

    state_e                state_q, state_d;
    logic [7:0]            lenlo_q, lenlo_d;
    logic [15:0]           rem_q, rem_d;
    logic [ADDR_WIDTH:0]   widx_q, widx_d;
    logic [1:0]            bidx_q, bidx_d;
    logic [instWidth-1:0]  word_q, word_d;
    logic [7:0]            xor_q, xor_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [instWidth-1:0]  wdata_q, wdata_d;

    logic                  xfer;
    logic [15:0]           n_len;

    assign xfer  = bus.in_valid && bus.in_ready;
    assign n_len = {bus.in_data, lenlo_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LEN0;
            lenlo_q <= '0;
            rem_q   <= '0;
            widx_q  <= '0;
            bidx_q  <= '0;
            word_q  <= '0;
            xor_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            lenlo_q <= lenlo_d;
            rem_q   <= rem_d;
            widx_q  <= widx_d;
            bidx_q  <= bidx_d;
            word_q  <= word_d;
            xor_q   <= xor_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lenlo_d = lenlo_q;
        rem_d   = rem_q;
        widx_d  = widx_q;
        bidx_d  = bidx_q;
        word_d  = word_q;
        xor_d   = xor_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (xfer) begin
            unique case (state_q)
                S_LEN0: begin
                    lenlo_d = bus.in_data;
                    state_d = S_LEN1;
                end
                S_LEN1: begin
                    rem_d = n_len;
                    if ({1'b0, n_len} > MAX_N) begin
                        state_d = S_ERR;
                    end else if (n_len == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    word_d[{bidx_q, 3'b000} +: 8] = bus.in_data;
                    xor_d  = xor_q ^ bus.in_data;
                    bidx_d = bidx_q + 2'd1;
                    // Index past the top of memory cannot occur for a legal N; treat as corrupt.
                    if (bidx_q == 2'd3) begin
                        if (widx_q[ADDR_WIDTH]) begin
                            state_d = S_ERR;
                        end else begin
                            we_d    = 1'b1;
                            addr_d  = widx_q[ADDR_WIDTH-1:0];
                            wdata_d = word_d;
                            widx_d  = widx_q + 1'b1;
                            rem_d   = rem_q - 16'd1;
                            if (rem_q == 16'd1) begin
                                state_d = S_CSUM;
                            end
                        end
                    end
                end
                S_CSUM: begin
                    state_d = (bus.in_data == xor_q) ? S_DONE : S_ERR;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.in_ready = 1'b0;
        cpu_rst      = 1'b1;
        done         = 1'b0;
        err          = 1'b0;
        unique case (state_q)
            S_LEN0, S_LEN1, S_DATA, S_CSUM: bus.in_ready = !rst;
            S_DONE: begin
                cpu_rst = 1'b0;
                done    = 1'b1;
            end
            S_ERR: err = 1'b1;
            default: ;
        endcase
    end

    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader: frames driven with random gaps
// and compared against a byte-stream reference model.
module tb_inst_mem_loader;

    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst;
    logic cpu_rst, done, err;

    always #5 clk = ~clk;

    inst_mem_loader_if #(.ADDR_WIDTH(AW), .instWidth(32)) bus ();

    inst_mem_loader #(.instWidth(32), .ADDR_WIDTH(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .cpu_rst (cpu_rst),
        .done    (done),
        .err     (err)
    );

    int total = 0;
    int bad   = 0;
    int wr_cnt = 0;

    always @(negedge clk) if (bus.mem_we === 1'b1) wr_cnt = wr_cnt + 1;

    logic          obs_we[$];
    logic [AW-1:0] obs_addr[$];
    logic [31:0]   obs_data[$];
    logic          obs_done[$];
    logic          obs_err[$];
    logic          obs_cpu[$];

    bit            exp_we[$];
    logic [AW-1:0] exp_addr[$];
    logic [31:0]   exp_data[$];
    bit            exp_done, exp_err;
    int            exp_nw;

    // Reference: decode the frame directly from its byte layout.
    function automatic void model(input logic [7:0] s[$]);
        int n;
        logic [7:0] x;
        exp_we.delete(); exp_addr.delete(); exp_data.delete();
        foreach (s[p]) begin
            exp_we.push_back(1'b0); exp_addr.push_back('0); exp_data.push_back('0);
        end
        exp_done = 1'b0; exp_err = 1'b0; exp_nw = 0;
        n = {s[1], s[0]};
        if (n > (1 << AW)) begin
            exp_err = 1'b1;
            return;
        end
        x = 8'h00;
        for (int j = 0; j < n; j++) begin
            int p;
            p = 2 + 4 * j + 3;
            exp_we[p]   = 1'b1;
            exp_addr[p] = AW'(j);
            exp_data[p] = {s[p], s[p-1], s[p-2], s[p-3]};
            exp_nw++;
        end
        for (int p = 2; p < 2 + 4 * n; p++) x ^= s[p];
        if (s[2 + 4 * n] == x) exp_done = 1'b1;
        else exp_err = 1'b1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] s[$], input int maxgap);
        obs_we.delete(); obs_addr.delete(); obs_data.delete();
        obs_done.delete(); obs_err.delete(); obs_cpu.delete();
        foreach (s[p]) begin
            int g;
            bit ok;
            g = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
            repeat (g) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
            end
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = s[p];
            ok = 1'b0;
            for (int k = 0; k < 20 && !ok; k++) begin
                #1;
                ok = (bus.in_ready === 1'b1);
                @(posedge clk);
                if (!ok) @(negedge clk);
            end
            if (!ok) begin
                total++; bad++;
                $display("FAIL stall byte %0d: in_ready stayed 0, required 1", p);
                bus.in_valid = 1'b0;
                return;
            end
            #1;
            obs_we.push_back(bus.mem_we);
            obs_addr.push_back(bus.mem_addr);
            obs_data.push_back(bus.mem_wdata);
            obs_done.push_back(done);
            obs_err.push_back(err);
            obs_cpu.push_back(cpu_rst);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    function automatic void two_word(output logic [7:0] s[$], input logic [7:0] cs);
        s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
              8'h93, 8'h00, 8'h10, 8'h00, cs};
    endfunction

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", bus.in_ready); end
        total++;
        if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b want=0", bus.mem_we); end
        total++;
        if (bus.mem_addr !== '0) begin bad++; $display("FAIL rst_addr got=%h want=0", bus.mem_addr); end
        total++;
        if (bus.mem_wdata !== '0) begin bad++; $display("FAIL rst_wdata got=%h want=0", bus.mem_wdata); end
        total++;
        if (cpu_rst !== 1'b1) begin bad++; $display("FAIL rst_cpu got=%b want=1", cpu_rst); end
        total++;
        if (done !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL rst_flags done=%b err=%b want 0 0", done, err); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL ready_after_rst got=%b want=1", bus.in_ready); end
    endtask

    task automatic test_two_word();
        logic [7:0] s[$];
        int base, l;
        two_word(s, 8'h90);
        do_reset();
        base = wr_cnt;
        run_frame(s, 0);
        model(s);
        l = s.size() - 1;
        foreach (exp_we[p]) begin
            total++;
            if (obs_we[p] !== exp_we[p] || (exp_we[p] && (obs_addr[p] !== exp_addr[p] || obs_data[p] !== exp_data[p]))) begin
                bad++;
                $display("FAIL two_word byte %0d: we=%b a=%h d=%h want we=%b a=%h d=%h", p, obs_we[p], obs_addr[p], obs_data[p], exp_we[p], exp_addr[p], exp_data[p]);
            end
        end
        total++;
        if (obs_done[l] !== exp_done || obs_err[l] !== exp_err || obs_cpu[l] !== !exp_done) begin
            bad++;
            $display("FAIL two_word_end done=%b err=%b cpu=%b want %b %b %b", obs_done[l], obs_err[l], obs_cpu[l], exp_done, exp_err, !exp_done);
        end
        total++;
        if (wr_cnt - base !== exp_nw) begin bad++; $display("FAIL two_word_nwr got=%0d want=%0d", wr_cnt - base, exp_nw); end
    endtask

    task automatic test_bad_csum();
        logic [7:0] s[$];
        int base, l;
        two_word(s, 8'h91);
        do_reset();
        base = wr_cnt;
        run_frame(s, 0);
        model(s);
        l = s.size() - 1;
        foreach (exp_we[p]) begin
            total++;
            if (obs_we[p] !== exp_we[p] || (exp_we[p] && (obs_addr[p] !== exp_addr[p] || obs_data[p] !== exp_data[p]))) begin
                bad++;
                $display("FAIL bad_csum byte %0d: we=%b a=%h d=%h want we=%b a=%h d=%h", p, obs_we[p], obs_addr[p], obs_data[p], exp_we[p], exp_addr[p], exp_data[p]);
            end
        end
        total++;
        if (obs_done[l] !== 1'b0 || obs_err[l] !== 1'b1 || obs_cpu[l] !== 1'b1) begin
            bad++;
            $display("FAIL bad_csum_end done=%b err=%b cpu=%b want 0 1 1", obs_done[l], obs_err[l], obs_cpu[l]);
        end
        total++;
        if (wr_cnt - base !== exp_nw) begin bad++; $display("FAIL bad_csum_nwr got=%0d want=%0d", wr_cnt - base, exp_nw); end
        total++;
        if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bad_csum_ready got=%b want=0", bus.in_ready); end
    endtask

    task automatic test_empty();
        logic [7:0] s[$];
        int base;
        s = '{8'h00, 8'h00, 8'h00};
        do_reset();
        base = wr_cnt;
        run_frame(s, 0);
        total++;
        if (wr_cnt - base !== 0) begin bad++; $display("FAIL empty_nwr got=%0d want=0", wr_cnt - base); end
        total++;
        if (obs_done[2] !== 1'b1 || obs_err[2] !== 1'b0 || obs_cpu[2] !== 1'b0) begin
            bad++;
            $display("FAIL empty_end done=%b err=%b cpu=%b want 1 0 0", obs_done[2], obs_err[2], obs_cpu[2]);
        end
    endtask

    task automatic test_oversize();
        logic [7:0] s[$];
        int base;
        s = '{8'h01, 8'h04};
        do_reset();
        base = wr_cnt;
        run_frame(s, 0);
        total++;
        if (obs_err[1] !== 1'b1 || obs_done[1] !== 1'b0 || obs_cpu[1] !== 1'b1) begin
            bad++;
            $display("FAIL oversize_end done=%b err=%b cpu=%b want 0 1 1", obs_done[1], obs_err[1], obs_cpu[1]);
        end
        repeat (3) @(negedge clk);
        total++;
        if (wr_cnt - base !== 0 || bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL oversize_quiet nwr=%0d ready=%b want 0 0", wr_cnt - base, bus.in_ready);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] s[$];
        int base, l;
        two_word(s, 8'h90);
        model(s);
        l = s.size() - 1;
        for (int it = 0; it < 3; it++) begin
            do_reset();
            base = wr_cnt;
            run_frame(s, 4);
            foreach (exp_we[p]) begin
                total++;
                if (obs_we[p] !== exp_we[p] || (exp_we[p] && (obs_addr[p] !== exp_addr[p] || obs_data[p] !== exp_data[p]))) begin
                    bad++;
                    $display("FAIL gaps it%0d byte %0d: we=%b a=%h d=%h want we=%b a=%h d=%h", it, p, obs_we[p], obs_addr[p], obs_data[p], exp_we[p], exp_addr[p], exp_data[p]);
                end
            end
            total++;
            if (obs_done[l] !== 1'b1 || obs_cpu[l] !== 1'b0 || wr_cnt - base !== 2) begin
                bad++;
                $display("FAIL gaps_end it%0d done=%b cpu=%b nwr=%0d want 1 0 2", it, obs_done[l], obs_cpu[l], wr_cnt - base);
            end
        end
    endtask

    task automatic test_reset_midload();
        logic [7:0] s[$], h[$];
        int base, l;
        two_word(s, 8'h90);
        h = s[0:5];
        do_reset();
        run_frame(h, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (bus.in_ready !== 1'b0 || cpu_rst !== 1'b1 || bus.mem_we !== 1'b0) begin
            bad++;
            $display("FAIL midrst ready=%b cpu=%b we=%b want 0 1 0", bus.in_ready, cpu_rst, bus.mem_we);
        end
        @(negedge clk);
        rst = 1'b0;
        base = wr_cnt;
        run_frame(s, 1);
        model(s);
        l = s.size() - 1;
        total++;
        if (obs_we[5] !== 1'b1 || obs_addr[5] !== '0 || obs_data[5] !== 32'h00000013) begin
            bad++;
            $display("FAIL midrst_w0 we=%b a=%h d=%h want 1 000 00000013", obs_we[5], obs_addr[5], obs_data[5]);
        end
        total++;
        if (obs_done[l] !== 1'b1 || obs_cpu[l] !== 1'b0 || wr_cnt - base !== exp_nw) begin
            bad++;
            $display("FAIL midrst_end done=%b cpu=%b nwr=%0d want 1 0 %0d", obs_done[l], obs_cpu[l], wr_cnt - base, exp_nw);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            logic [7:0] s[$];
            logic [7:0] x;
            logic [31:0] w;
            int n, base, l;
            n = $urandom_range(1, 16);
            s.push_back(8'(n));
            s.push_back(8'(n >> 8));
            x = 8'h00;
            for (int j = 0; j < n; j++) begin
                w = $urandom;
                for (int b = 0; b < 4; b++) begin
                    s.push_back(w[b*8 +: 8]);
                    x ^= w[b*8 +: 8];
                end
            end
            if ($urandom_range(0, 2) == 0) x ^= 8'(1 << $urandom_range(0, 7));
            s.push_back(x);
            do_reset();
            base = wr_cnt;
            run_frame(s, 2);
            model(s);
            l = s.size() - 1;
            foreach (exp_we[p]) begin
                total++;
                if (obs_we[p] !== exp_we[p] || (exp_we[p] && (obs_addr[p] !== exp_addr[p] || obs_data[p] !== exp_data[p]))) begin
                    bad++;
                    $display("FAIL random it%0d byte %0d: we=%b a=%h d=%h want we=%b a=%h d=%h", it, p, obs_we[p], obs_addr[p], obs_data[p], exp_we[p], exp_addr[p], exp_data[p]);
                end
            end
            total++;
            if (obs_done[l] !== exp_done || obs_err[l] !== exp_err || obs_cpu[l] !== !exp_done || wr_cnt - base !== exp_nw) begin
                bad++;
                $display("FAIL random_end it%0d done=%b err=%b cpu=%b nwr=%0d want %b %b %b %0d", it, obs_done[l], obs_err[l], obs_cpu[l], wr_cnt - base, exp_done, exp_err, !exp_done, exp_nw);
            end
        end
    endtask

    task automatic test_full_memory();
        logic [7:0] s[$];
        logic [7:0] x;
        logic [31:0] w;
        int base, l, lw, mis;
        s = '{8'h00, 8'h04};
        x = 8'h00;
        for (int j = 0; j < 1024; j++) begin
            w = j;
            for (int b = 0; b < 4; b++) begin
                s.push_back(w[b*8 +: 8]);
                x ^= w[b*8 +: 8];
            end
        end
        s.push_back(x);
        do_reset();
        base = wr_cnt;
        run_frame(s, 0);
        model(s);
        l  = s.size() - 1;
        lw = l - 1;
        mis = 0;
        foreach (exp_we[p]) begin
            if (obs_we[p] !== exp_we[p] || (exp_we[p] && (obs_addr[p] !== exp_addr[p] || obs_data[p] !== exp_data[p]))) mis++;
        end
        total++;
        if (mis != 0) begin bad++; $display("FAIL full_writes mismatched_bytes=%0d want 0", mis); end
        total++;
        if (obs_we[lw] !== 1'b1 || obs_addr[lw] !== 10'd1023 || obs_data[lw] !== 32'h000003FF) begin
            bad++;
            $display("FAIL full_last we=%b a=%h d=%h want 1 3ff 000003ff", obs_we[lw], obs_addr[lw], obs_data[lw]);
        end
        total++;
        if (obs_done[l] !== 1'b1 || obs_cpu[l] !== 1'b0 || wr_cnt - base !== 1024) begin
            bad++;
            $display("FAIL full_end done=%b cpu=%b nwr=%0d want 1 0 1024", obs_done[l], obs_cpu[l], wr_cnt - base);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        test_reset();
        test_two_word();
        test_bad_csum();
        test_empty();
        test_oversize();
        test_gaps();
        test_reset_midload();
        test_random();
        test_full_memory();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inst_mem_loader.md
# inst_mem_loader

Runtime boot loader: the writer side of the RISC-V core's instruction memory. It receives a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. It writes those words into `u_inst_mem` through a dedicated write port and holds the core in reset until the image is complete and its checksum verifies. This lets the FFT/IFFT program images be loaded in hardware instead of by `$readmemh`.

## Interface
- `instWidth`, 32, instruction word width; fixed at 32 because four bytes make one word.
- `ADDR_WIDTH`, 10, word-address width of the instruction memory; depth is 2**ADDR_WIDTH words.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset: one clock; synchronous, active-high.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader can accept a byte; a byte transfers on any cycle where `in_valid && in_ready`.
- `mem_we`  out  1  one-cycle write strobe to the instruction memory.
- `mem_addr`  out  ADDR_WIDTH  word address of the write.
- `mem_wdata`  out  instWidth  word to write.
- `cpu_rst`  out  1  reset to the core; high until the load completes successfully.
- `done`  out  1  sticky; the image loaded and the checksum matched.
- `err`  out  1  sticky; the length was illegal or the checksum did not match.

## Operation
- Frame format, in byte order:
  - LEN_LO, LEN_HI: 16-bit word count N, little-endian.
  - 4·N data bytes: each word is sent LSB first.
  - CSUM: XOR of all 4·N data bytes. The header bytes are excluded.
- States: S_LEN0 → S_LEN1 → S_DATA → S_CSUM → S_DONE or S_ERR.
  - S_LEN0: accept LEN_LO, then go to S_LEN1.
  - S_LEN1: accept LEN_HI.
    - If N > 2**ADDR_WIDTH: go to S_ERR.
    - If N == 0: go to S_CSUM.
    - Otherwise: go to S_DATA.
  - S_DATA:
    - A 2-bit byte counter shifts bytes into a word register at `byte_idx*8`.
    - On the 4th byte, issue a write, increment the word index and decrement the remaining count.
    - After the last word, go to S_CSUM.
  - S_CSUM: accept one byte.
    - If it equals the running XOR: go to S_DONE.
    - Otherwise: go to S_ERR.
  - S_DONE and S_ERR are terminal. Only `rst` leaves them.
- Register widths and arithmetic:
  - The word index is ADDR_WIDTH+1 bits and starts at 0.
  - The running XOR is 8 bits, cleared at reset.
  - The remaining count is 16 bits, so N = 2**ADDR_WIDTH is legal and fills memory exactly.
- `in_ready`: 1 in S_LEN0, S_LEN1, S_DATA and S_CSUM; 0 in S_DONE, S_ERR and during the reset cycle. No other backpressure exists; memory accepts a write every cycle.
- `cpu_rst`: 1 in every state except S_DONE.
- Bytes presented while `in_valid` is low are ignored. Gaps of any length between bytes are legal.
- `rst` asserted mid-load: the next state is S_LEN0 and all counters and the XOR clear. Words already written stay in memory and are not erased. `cpu_rst` stays high.

## Timing
- Reset values: `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_rst`=1, `done`=0, `err`=0. State is S_LEN0.
- `in_ready` rises on the first cycle after `rst` deasserts.
- Write timing: if the 4th byte of word k transfers in cycle T, then in cycle T+1:
  - `mem_we`=1, `mem_addr`=k, `mem_wdata`=assembled word.
  - `mem_we` is 0 otherwise.
  - `mem_addr` and `mem_wdata` hold their last value between writes.
- Back-to-back bytes every cycle sustain one write every 4 cycles.
- If the CSUM byte transfers in cycle T, then in cycle T+1 either:
  - `done`=1 and `cpu_rst`=0, both switching on the same edge; or
  - `err`=1 with `cpu_rst` still 1.
- If LEN_HI transfers in cycle T with an illegal N, `err`=1 at T+1.
- The last data write (T+1) and entry to S_CSUM happen on the same edge. A CSUM byte presented at T+1 is accepted.

## Test plan
- Two-word image:
  - Stream `02 00 13 00 00 00 93 00 10 00 90`, one byte per cycle.
  - Writes (addr 0, 0x00000013) then (addr 1, 0x00100093), each one cycle after its 4th byte.
  - `done`=1 and `cpu_rst`=0 one cycle after 0x90 is accepted.
- Bad checksum:
  - Same stream with a final byte of 0x91.
  - Both writes occur; `err`=1 and `cpu_rst` stays 1; `in_ready`=0 afterwards.
- Empty image:
  - Stream `00 00 00`.
  - No `mem_we`; `done`=1 after the third byte.
- Oversize length:
  - With ADDR_WIDTH=10, stream `01 04` (N=1025).
  - `err`=1 one cycle after the second byte; no writes.
- Gaps and reset:
  - Random `in_valid` gaps on the two-word stream give identical writes and `done`.
  - Asserting `rst` after the 6th byte then replaying the full stream writes addr 0 again and ends with `done`=1.
- Full memory:
  - N=1024 with data word i = i.
  - The last write is at addr 1023 with data 0x000003FF; the correct XOR gives `done`=1.
